// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
// Program-counter register and instruction-fetch sequencer. It issues fetches
// to instruction memory over a valid/ready handshake. The PC advances
// sequentially, or jumps to a branch/jump redirect target. The PC is held
// across decode and bus stalls.
// A redirect that arrives while a request is still waiting for the memory is
// parked in a pending register. It is applied on the accept edge, so the
// address on the bus never changes mid-handshake.

module pc_fetch_controller #(
  parameter int                   DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instruction_stall,
  input  logic                 bus_stall,
  input  logic                 redirect_valid,
  input  logic [DATA_SIZE-1:0] redirect_pc,
  input  logic                 im_ready,
  output logic                 im_req,
  output logic [DATA_SIZE-1:0] im_addr,
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] pc,
  output logic [DATA_SIZE-1:0] past_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [DATA_SIZE-1:0] PC_STEP    = {{(DATA_SIZE-3){1'b0}}, 3'd4};
  localparam logic [DATA_SIZE-1:0] ALIGN_MASK = {{(DATA_SIZE-2){1'b0}}, 2'b11};

  state_t               state_r, state_s;
  logic [DATA_SIZE-1:0] pc_r, pc_s;
  logic [DATA_SIZE-1:0] past_pc_r, past_pc_s;
  logic                 pend_valid_r, pend_valid_s;
  logic [DATA_SIZE-1:0] pend_pc_r, pend_pc_s;

  logic                 accept_s;
  logic                 stall_s;
  logic                 redir_s;
  logic [DATA_SIZE-1:0] target_s;

  // Request qualifiers; redirects are frozen along with the rest of the pipe on a bus stall
  always_comb begin
    im_req      = (state_r == S_REQ);
    accept_s    = im_req && im_ready;
    stall_s     = instruction_stall || bus_stall;
    redir_s     = redirect_valid && !bus_stall;
    target_s    = redirect_pc & ~ALIGN_MASK;
    fetch_valid = accept_s && !redir_s && !pend_valid_r;
    im_addr     = pc_r;
    pc          = pc_r;
    past_pc     = past_pc_r;
  end

  // Next-state and PC/pending-redirect update logic
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    past_pc_s    = past_pc_r;
    pend_valid_s = pend_valid_r;
    pend_pc_s    = pend_pc_r;
    case (state_r)
      S_IDLE: begin
        state_s = S_REQ;
      end
      S_REQ: begin
        if (accept_s) begin
          past_pc_s    = pc_r;
          pend_valid_s = 1'b0;
          if (redir_s) begin
            pc_s = target_s;
          end else if (pend_valid_r) begin
            pc_s = pend_pc_r;
          end else begin
            pc_s = pc_r + PC_STEP;
          end
          if (stall_s) begin
            state_s = S_HOLD;
          end else begin
            state_s = S_REQ;
          end
        end else begin
          // Keep address stable until accepted; park any redirect for later
          if (redir_s) begin
            pend_valid_s = 1'b1;
            pend_pc_s    = target_s;
          end else begin
            pend_valid_s = pend_valid_r;
          end
          state_s = S_REQ;
        end
      end
      S_HOLD: begin
        if (redir_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (stall_s) begin
          state_s = S_HOLD;
        end else begin
          state_s = S_REQ;
        end
      end
      default: begin
        state_s      = S_IDLE;
        pend_valid_s = 1'b0;
      end
    endcase
  end

  // State, PC and pending-redirect registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      past_pc_r    <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= RESET_PC;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      past_pc_r    <= past_pc_s;
      pend_valid_r <= pend_valid_s;
      pend_pc_r    <= pend_pc_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: each step drives inputs just after a
// rising edge and checks outputs against hand-computed values.

module tb_pc_fetch_controller;

  logic        clk;
  logic        rst;
  logic        instruction_stall;
  logic        bus_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_ready;
  logic        im_req;
  logic [31:0] im_addr;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] past_pc;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_controller #(
    .DATA_SIZE(32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_stall(instruction_stall),
    .bus_stall        (bus_stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .im_ready         (im_ready),
    .im_req           (im_req),
    .im_addr          (im_addr),
    .fetch_valid      (fetch_valid),
    .pc               (pc),
    .past_pc          (past_pc)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b0;
    instruction_stall = 1'b0;
    bus_stall         = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    im_ready          = 1'b1;
    #3;
    check("rst_pc",      pc,                  32'h0);
    check("rst_past",    past_pc,             32'h0);
    check("rst_addr",    im_addr,             32'h0);
    check("rst_req",     {31'd0, im_req},     32'h0);
    check("rst_fv",      {31'd0, fetch_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("idle_req",    {31'd0, im_req},     32'h0);
    tick();
    // First edge after release: S_REQ
    check("req_rise",    {31'd0, im_req},     32'h1);
    check("req_pc0",     pc,                  32'h0);
    check("fv_acc0",     {31'd0, fetch_valid}, 32'h1);
    tick();
    check("seq_pc4",     pc,                  32'h4);
    check("seq_past0",   past_pc,             32'h0);
    check("fv_acc4",     {31'd0, fetch_valid}, 32'h1);
    tick();
    check("seq_pc8",     pc,                  32'h8);
    check("seq_past4",   past_pc,             32'h4);
    tick();
    check("seq_pcC",     pc,                  32'hC);
    check("seq_past8",   past_pc,             32'h8);
    tick();
    check("seq_pc10",    pc,                  32'h10);
    // Memory not ready for 3 cycles at 0x10
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      check("wait_req",  {31'd0, im_req},     32'h1);
      check("wait_addr", im_addr,             32'h10);
      check("wait_fv",   {31'd0, fetch_valid}, 32'h0);
    end
    im_ready = 1'b1;
    #1;
    check("ready_fv",    {31'd0, fetch_valid}, 32'h1);
    tick();
    check("ready_pc",    pc,                  32'h14);
    check("ready_past",  past_pc,             32'h10);
    // Redirect together with accept: new target, fetch killed
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("redacc_fv",   {31'd0, fetch_valid}, 32'h0);
    tick();
    check("redacc_pc",   pc,                  32'h40);
    check("redacc_past", past_pc,             32'h14);
    // Redirect to 0x203 while request at 0x40 waits
    im_ready    = 1'b0;
    redirect_pc = 32'h203;
    #1;
    check("pend_fv0",    {31'd0, fetch_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    im_ready       = 1'b1;
    #1;
    check("pend_hold",   im_addr,             32'h40);
    check("pend_fv",     {31'd0, fetch_valid}, 32'h0);
    tick();
    check("pend_pc",     pc,                  32'h200);
    check("pend_past",   past_pc,             32'h40);
    check("pend_fv1",    {31'd0, fetch_valid}, 32'h1);
    tick();
    check("pend_seq",    pc,                  32'h204);
    // Jump to 0x8, then accept at 0x8 under instruction_stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    tick();
    redirect_valid    = 1'b0;
    instruction_stall = 1'b1;
    #1;
    check("stl_acc_pc",  pc,                  32'h8);
    tick();
    check("hold1_req",   {31'd0, im_req},     32'h0);
    check("hold1_pc",    pc,                  32'hC);
    tick();
    check("hold2_req",   {31'd0, im_req},     32'h0);
    check("hold2_pc",    pc,                  32'hC);
    instruction_stall = 1'b0;
    #1;
    check("hold3_req",   {31'd0, im_req},     32'h0);
    tick();
    check("resume_req",  {31'd0, im_req},     32'h1);
    check("resume_pc",   pc,                  32'hC);
    // bus_stall with redirect to 0x100: redirect ignored, fetch still valid
    bus_stall      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("bus_fv",      {31'd0, fetch_valid}, 32'h1);
    tick();
    check("bus_pc",      pc,                  32'h10);
    check("bus_req",     {31'd0, im_req},     32'h0);
    tick();
    check("bus_hold_pc", pc,                  32'h10);
    // Redirect in S_HOLD with decode stall only: pc updated directly
    bus_stall         = 1'b0;
    instruction_stall = 1'b1;
    redirect_pc       = 32'h300;
    tick();
    check("hred_pc",     pc,                  32'h300);
    check("hred_req",    {31'd0, im_req},     32'h0);
    instruction_stall = 1'b0;
    redirect_valid    = 1'b0;
    tick();
    check("hred_resume", {31'd0, im_req},     32'h1);
    check("hred_pc2",    pc,                  32'h300);
    // Unaligned redirect to top of address space, then wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("top_pc",      pc,                  32'hFFFF_FFFC);
    check("top_past",    past_pc,             32'h300);
    tick();
    check("wrap_pc",     pc,                  32'h0);
    check("wrap_past",   past_pc,             32'hFFFF_FFFC);
    tick();
    check("post_wrap",   pc,                  32'h4);
    // Park a redirect, then reset asynchronously mid-request
    im_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    tick();
    redirect_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc",     pc,                  32'h0);
    check("arst_past",   past_pc,             32'h0);
    check("arst_req",    {31'd0, im_req},     32'h0);
    @(negedge clk);
    rst      = 1'b1;
    im_ready = 1'b1;
    tick();
    check("arst_req2",   {31'd0, im_req},     32'h1);
    check("arst_fv",     {31'd0, fetch_valid}, 32'h1);
    tick();
    check("arst_nopend", pc,                  32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
